gf_pow_seq: RTL and testbench
=============================

# gf_pow_seq

Sequential, parametrised exponentiator over GF(2^W): computes p = a^e mod POLY using constant-time, MSB-first square-and-multiply with a single time-shared field multiplier. It generalises the fixed-exponent combinational power chains used in the SEED datapath: the exponent is a runtime input, the field width and reduction polynomial are parameters, and results are delivered over valid/ready handshakes. Its first consumer is the serialized SEED S-box path, where it is run with e = 247 and e = 251.

## Interface

- W, 8, field degree; operand and result width.
- POLY, 9'h163, reduction polynomial, W+1 bits, bit W set (SEED: x^8+x^6+x^5+x+1).
- EXP_W, 8, exponent width in bits.

- clk  input  1  rising-edge clock; one clock for the whole block.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block idle and able to accept.
- a  input  W  base operand.
- e  input  EXP_W  exponent.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- p  output  W  result a^e.

## Operation

- States: IDLE, SQR, MUL, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch a_q=a, e_q=e; r=1; bit index cnt=EXP_W-1; go to SQR.
- SQR: r <= gf_mul(r, r); go to MUL.
- MUL: r <= gf_mul(r, e_q[cnt] ? a_q : 1). The multiply runs even when the bit is 0 (constant time). If cnt==0, go to DONE; else cnt <= cnt-1 and go to SQR.
- DONE: out_valid=1, p=r. On out_ready, go to IDLE. p holds stable while out_valid=1 && out_ready=0.
- Arithmetic: carry-less product of two W-bit values (2W-1 bits), reduced modulo POLY. All results are strictly W bits.
- Defined values: e=0 gives p=1 for any a, including 0^0=1. a=0 with e>0 gives p=0.
- No request overlap: in_ready=0 in SQR, MUL and DONE. Inputs are ignored while in_ready=0.
- Reset, asynchronous and valid at any time including mid-computation: state=IDLE, r=0, a_q=0, e_q=0, cnt=0. Outputs after reset: in_ready=1, out_valid=0, p=0. An in-flight computation is discarded with no partial output.

## Timing

- Request accepted at clock edge k. out_valid rises after edge k+2·EXP_W, i.e. 16 cycles for EXP_W=8. This latency is independent of a and e.
- Result handshake completes at the first edge where out_valid&&out_ready. in_ready is 1 in the following cycle.
- Best-case throughput is one result per 2·EXP_W+2 cycles (out_ready held high).
- Outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- The multiplier is the critical path: one W×W GF multiply plus reduction per cycle.

## Structure

- Shared package gf_pkg holds:
  - SEED_POLY = 9'h163
  - state enum {IDLE, SQR, MUL, DONE}
  - the SEED exponent constants SEED_E0 = 247 and SEED_E1 = 251
- One sub-module, gf_mul: purely combinational multiplier parametrised by W and POLY, with inputs x and y and output z. It is instantiated once.
- The top level holds the FSM, cnt, r, a_q, e_q and the operand mux.

## Test plan

- a=0x02, e=8 → p=0x63 after exactly 16 cycles, out_ready held high. in_ready must be low throughout.
- a=0x03, e=1 → p=0x03. a=0x00, e=0 → p=0x01. a=0x00, e=5 → p=0x00. All three must show the same 16-cycle latency.
- Sweep all nonzero a with e=255 → p=0x01 for every a. For each a, the result with e=254, multiplied by a in the bench model, equals 0x01.
- Backpressure: a=0x53, e=247. Hold out_ready=0 for 10 cycles after out_valid rises. p must stay stable and in_ready must stay 0. The new request presented during the stall is accepted only after the handshake.
- Reset mid-operation: assert rst_n=0 asynchronously at cycle 7 of a computation. Outputs go immediately to in_ready=1, out_valid=0, p=0. A fresh request after release (a=0x02, e=8) returns 0x63.
- Random a and e against a bench reference model for W=8 / POLY=0x163. Repeat with W=4 / POLY=5'h13, EXP_W=4: 8-cycle latency, and a=0x2, e=4 → p=0x3.

Source files
------------

// File: rtl/gf_pkg.sv
// gf_pkg: shared GF(2^W) constants and the exponentiator state encoding.
package gf_pkg;
   localparam logic [8:0] SEED_POLY = 9'h163;
   localparam int unsigned SEED_E0 = 247;
   localparam int unsigned SEED_E1 = 251;
   typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;
endpackage

// File: rtl/gf_mul.sv
// gf_mul: combinational GF(2^W) multiplier, carry-less product reduced modulo POLY.
module gf_mul #(
   parameter int unsigned W = 8,
   parameter logic [W:0] POLY = 9'h163
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] z
);
   logic [2*W-2:0] prod;
   always_comb begin
      prod = '0;
      for (int i = 0; i < W; i++)
         if (y[i]) prod = prod ^ ((2*W-1)'(x) << i);
      // fold high terms down from the top so each step clears one bit
      for (int i = 2*W-2; i >= int'(W); i--)
         if (prod[i]) prod = prod ^ ((2*W-1)'(POLY) << (i - W));
      z = prod[W-1:0];
   end
endmodule

// File: rtl/gf_pow_seq.sv
// gf_pow_seq: constant-time MSB-first square-and-multiply a^e over GF(2^W)
// with one shared multiplier and valid/ready handshakes.
module gf_pow_seq import gf_pkg::*; #(
   parameter int unsigned W = 8,
   parameter logic [W:0] POLY = (W+1)'(SEED_POLY),
   parameter int unsigned EXP_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [EXP_W-1:0] e,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     p
);
   localparam int unsigned CW = EXP_W > 1 ? $clog2(EXP_W) : 1;
   state_t           state_q;
   logic [W-1:0]     r_q, a_q, r_d, mul_y;
   logic [EXP_W-1:0] e_q;
   logic [CW-1:0]    cnt_q;
   logic             in_ready_q, out_valid_q;
   // a zero exponent bit still multiplies by 1 to keep timing data-independent
   assign mul_y = state_q == SQR ? r_q : (e_q[cnt_q] ? a_q : W'(1));
   gf_mul #(.W(W), .POLY(POLY)) u_mul (.x(r_q), .y(mul_y), .z(r_d));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         r_q         <= '0;
         a_q         <= '0;
         e_q         <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               a_q        <= a;
               e_q        <= e;
               r_q        <= W'(1);
               cnt_q      <= CW'(EXP_W - 1);
               in_ready_q <= 1'b0;
               state_q    <= SQR;
            end
            SQR: begin
               r_q     <= r_d;
               state_q <= MUL;
            end
            MUL: begin
               r_q <= r_d;
               if (cnt_q == '0) begin
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q   <= cnt_q - 1'b1;
                  state_q <= SQR;
               end
            end
            DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign p         = r_q;
endmodule

// File: tb/tb_gf_pow_seq.sv
// tb_gf_pow_seq: scoreboard bench for gf_pow_seq at W=8/POLY=0x163 and W=4/POLY=0x13.
module tb_gf_pow_seq;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   logic iv8 = 1'b0, ir8, ov8, or8 = 1'b1;
   logic [7:0] a8 = '0, e8 = '0, p8;
   logic iv4 = 1'b0, ir4, ov4, or4 = 1'b1;
   logic [3:0] a4 = '0, e4 = '0, p4;
   typedef struct { int p; int a; bit inv; int acc; } exp_t;
   exp_t q8[$], q4[$];
   exp_t x8, x4;
   int checks = 0, fails = 0, cyc = 0;
   bit pv8 = 1'b0, pv4 = 1'b0;

   gf_pow_seq #(.W(8), .POLY(9'h163), .EXP_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .e(e8),
      .out_valid(ov8), .out_ready(or8), .p(p8));
   gf_pow_seq #(.W(4), .POLY(5'h13), .EXP_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .e(e4),
      .out_valid(ov4), .out_ready(or4), .p(p4));

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
      end
   endtask

   // shift-and-xor reference: walk y LSB-first, doubling x with reduction each step
   function automatic int gmul(input int x, input int y, input int w, input int poly);
      int r = 0;
      for (int i = 0; i < w; i++) begin
         if (y & 1) r ^= x;
         y >>= 1;
         x <<= 1;
         if ((x >> w) & 1) x ^= poly;
      end
      return r;
   endfunction

   function automatic int gpow(input int a, input int e, input int w, input int poly);
      int r = 1;
      for (int i = 0; i < e; i++) r = gmul(r, a, w, poly);
      return r;
   endfunction

   always begin
      @(negedge clk); #1;
      if (ov8 && !pv8 && q8.size() > 0) chk("lat8", cyc - q8[0].acc, 16);
      if (ov8 && or8) begin
         if (q8.size() == 0) chk("unexpected8", 1, 0);
         else begin
            x8 = q8.pop_front();
            if (x8.inv) chk("inv8", gmul(int'(p8), x8.a, 8, 'h163), 1);
            else chk("p8", int'(p8), x8.p);
         end
      end
      pv8 = ov8;
   end

   always begin
      @(negedge clk); #1;
      if (ov4 && !pv4 && q4.size() > 0) chk("lat4", cyc - q4[0].acc, 8);
      if (ov4 && or4) begin
         if (q4.size() == 0) chk("unexpected4", 1, 0);
         else begin
            x4 = q4.pop_front();
            chk("p4", int'(p4), x4.p);
         end
      end
      pv4 = ov4;
   end

   task automatic req8(input int a, input int e, input int ex, input bit inv);
      int n = 0;
      iv8 = 1'b1; a8 = 8'(a); e8 = 8'(e);
      while (!ir8 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("req8_timeout", n, 0);
      else q8.push_back('{ex, a, inv, cyc + 1});
      @(negedge clk);
      iv8 = 1'b0;
   endtask

   task automatic req4(input int a, input int e, input int ex);
      int n = 0;
      iv4 = 1'b1; a4 = 4'(a); e4 = 4'(e);
      while (!ir4 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("req4_timeout", n, 0);
      else q4.push_back('{ex, a, 1'b0, cyc + 1});
      @(negedge clk);
      iv4 = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q8.size() != 0 || q4.size() != 0 || !ir8 || !ir4) && n < 500) begin
         @(negedge clk); n++;
      end
      if (n >= 500) chk("drain_timeout", n, 0);
   endtask

   initial begin
      int n, ra, re;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", int'(ir8), 1);
      chk("rst_out_valid", int'(ov8), 0);
      chk("rst_p", int'(p8), 0);
      rst_n = 1'b1;
      @(negedge clk);
      req8('h02, 8, 'h63, 1'b0);
      repeat (15) begin chk("busy_in_ready", int'(ir8), 0); @(negedge clk); end
      drain();
      req8('h03, 1, 'h03, 1'b0);
      req8('h00, 0, 'h01, 1'b0);
      req8('h00, 5, 'h00, 1'b0);
      for (int i = 1; i < 256; i++) req8(i, 255, 'h01, 1'b0);
      for (int i = 1; i < 256; i++) req8(i, 254, 'h01, 1'b1);
      drain();
      or8 = 1'b0;
      req8('h53, 247, gpow('h53, 247, 8, 'h163), 1'b0);
      n = 0;
      while (!ov8 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("bp_valid_timeout", n, 0);
      iv8 = 1'b1; a8 = 8'h02; e8 = 8'h08;
      repeat (10) begin
         @(negedge clk);
         chk("bp_p", int'(p8), gpow('h53, 247, 8, 'h163));
         chk("bp_in_ready", int'(ir8), 0);
         chk("bp_out_valid", int'(ov8), 1);
      end
      or8 = 1'b1;
      req8('h02, 8, 'h63, 1'b0);
      drain();
      iv8 = 1'b1; a8 = 8'h53; e8 = 8'd247;
      @(negedge clk);
      iv8 = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", int'(ir8), 1);
      chk("mid_rst_out_valid", int'(ov8), 0);
      chk("mid_rst_p", int'(p8), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      req8('h02, 8, 'h63, 1'b0);
      for (int i = 0; i < 20; i++) begin
         ra = int'($urandom_range(0, 255));
         re = int'($urandom_range(0, 255));
         req8(ra, re, gpow(ra, re, 8, 'h163), 1'b0);
      end
      drain();
      req4('h2, 4, 'h3);
      for (int i = 0; i < 12; i++) begin
         ra = int'($urandom_range(0, 15));
         re = int'($urandom_range(0, 15));
         req4(ra, re, gpow(ra, re, 4, 'h13));
      end
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
